// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the shift sequencer and its shifter.
package shift_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [2:0] {OP_NONE, OP_LSL, OP_ASL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_RSVD} shift_op_e;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} seq_state_e;
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: command and result handshakes of the shift sequencer.
interface shift_sequencer_if #(parameter int REP_W = 4);
    import shift_pkg::*;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data;
    logic [2:0]        cmd_op;
    logic [2:0]        cmd_count;
    logic [REP_W-1:0]  cmd_reps;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    modport master (
        output cmd_valid, cmd_data, cmd_op, cmd_count, cmd_reps, res_ready,
        input  cmd_ready, res_valid, res_data, busy
    );
    modport slave (
        input  cmd_valid, cmd_data, cmd_op, cmd_count, cmd_reps, res_ready,
        output cmd_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// shift_sequencer_shifter: combinational 8-bit shifter; clk only clocks its self-check.
module shift_sequencer_shifter
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic [DATA_W-1:0] d_in,
    input  shift_op_e         sel,
    input  logic [2:0]        shift_count,
    output logic [DATA_W-1:0] d_out
);
    logic signed [DATA_W-1:0] w_asr;
    logic [3:0]               w_inv;
    // Kept separate so the arithmetic shift is not demoted to logical by the unsigned mux.
    assign w_asr = $signed(d_in) >>> shift_count;
    assign w_inv = 4'd8 - {1'b0, shift_count};
    always_comb begin
        d_out = (sel == OP_LSL || sel == OP_ASL) ? d_in << shift_count :
                (sel == OP_LSR) ? d_in >> shift_count :
                (sel == OP_ASR) ? w_asr :
                (sel == OP_ROL) ? (d_in << shift_count) | (d_in >> w_inv) :
                (sel == OP_ROR) ? (d_in >> shift_count) | (d_in << w_inv) :
                d_in;
    end
    assert property (@(posedge clk) (sel == OP_RSVD || shift_count == 3'd0) |-> d_out == d_in);
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one shift command and applies it for a programmed number
// of passes, one pass per cycle, then holds the result on a valid/ready port.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int REP_W = 4
) (
    input logic             clk,
    input logic             rst,
    shift_sequencer_if.slave io_bus
);
    seq_state_e        r_state;
    logic [DATA_W-1:0] r_acc;
    shift_op_e         r_op;
    logic [2:0]        r_cnt;
    logic [REP_W-1:0]  r_rem;
    logic [DATA_W-1:0] w_shift;
    shift_sequencer_shifter u_shifter (
        .clk         (clk),
        .d_in        (r_acc),
        .sel         (r_op),
        .shift_count (r_cnt),
        .d_out       (w_shift)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_op    <= OP_NONE;
            r_cnt   <= '0;
            r_rem   <= '0;
        end else if (r_state == IDLE) begin
            if (io_bus.cmd_valid) begin
                r_acc   <= io_bus.cmd_data;
                r_op    <= shift_op_e'(io_bus.cmd_op);
                r_cnt   <= io_bus.cmd_count;
                r_rem   <= io_bus.cmd_reps;
                r_state <= (io_bus.cmd_reps == '0) ? DONE : EXEC;
            end
        end else if (r_state == EXEC) begin
            r_acc <= w_shift;
            r_rem <= r_rem - REP_W'(1);
            if (r_rem == REP_W'(1)) r_state <= DONE;
        end else if (io_bus.res_ready) begin
            r_state <= IDLE;
        end
    end
    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign io_bus.cmd_ready = (r_state == IDLE);
    assign io_bus.res_valid = (r_state == DONE);
    assign io_bus.busy      = (r_state == EXEC) || (r_state == DONE);
    assign io_bus.res_data  = r_acc;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Iterative front-end for the combinational 8-bit shifter. It accepts one shift command over a valid/ready handshake and holds the operand in an accumulator. It then drives the shifter with the accumulator, opcode and count, and re-registers the shifter's output once per cycle for a programmed number of passes. The final value is presented on a valid/ready result port. It sits directly upstream of the shifter: the shifter's data, select and count inputs are driven from this block's registers, and the shifter's output is consumed back into the accumulator.

## Interface
- REP_W, 4, width of pass-count field; max passes = 2^REP_W − 1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_data  in  8  signed operand
- cmd_op  in  3  shifter select: 000 none, 001 LSL, 010 ASL, 011 LSR, 100 ASR, 101 ROL, 110 ROR, 111 reserved (pass-through)
- cmd_count  in  3  shift amount per pass, 0–7
- cmd_reps  in  REP_W  number of passes
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  8  signed result (= accumulator)
- busy  out  1  high in EXEC or DONE

## Operation
- FSM states: IDLE, EXEC, DONE.
- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch acc ← cmd_data, op_q ← cmd_op, cnt_q ← cmd_count, rem ← cmd_reps.
  - If cmd_reps = 0, go to DONE. Otherwise go to EXEC.
- **EXEC**
  - Every cycle: acc ← shifter(acc, op_q, cnt_q) and rem ← rem − 1.
  - When rem = 1 at the edge, go to DONE.
  - Command inputs are ignored.
- **DONE**
  - res_valid = 1; res_data = acc, held stable.
  - On res_valid & res_ready, go to IDLE.
  - cmd_ready = 0 throughout DONE, including the handshake cycle.
- **Arithmetic**: 8-bit signed throughout.
  - LSL and ASL are identical and truncate to 8 bits.
  - ASR sign-fills, so repeated ASR saturates at 0xFF for negative operands and 0x00 for non-negative ones.
  - Rotates are modulo 8. N passes of count c are equivalent to a rotate by (N·c) mod 8.
  - Op 111 and count 0 leave acc unchanged but still consume passes.
- **Reset**
  - rst has priority over every handshake and state transition.
  - At any edge with rst = 1: state ← IDLE, acc ← 0, rem ← 0, op_q ← 0, cnt_q ← 0.
  - Reset values: cmd_ready 1, res_valid 0, res_data 0x00, busy 0.
  - Reset during EXEC or DONE discards the command; no res_valid is produced for it.

## Timing
- E0 is the command-acceptance edge.
- res_valid is first high after edge E_N, where N = cmd_reps. For N = 0, that is the cycle immediately after E0.
- The result is held until the res handshake edge; IDLE follows that edge.
- Minimum accept-to-accept spacing is N + 2 edges. There is no overlap of commands.
- cmd_ready, res_valid and busy are decoded from the state register only. There is no combinational path from any input to any output.
- The shifter path is purely combinational between acc and acc's D input, giving one pass per cycle.

## Structure
- Package shift_pkg holds:
  - localparam DATA_W = 8;
  - typedef enum logic [2:0] shift_op_e {OP_NONE, OP_LSL, OP_ASL, OP_LSR, OP_ASR, OP_ROL, OP_ROR, OP_RSVD};
  - typedef enum logic [1:0] seq_state_e {IDLE, EXEC, DONE}.
- One sub-module: the existing shifter.
  - Instance u_shifter, with clk tied to clk.
  - d_in = acc, sel = op_q, shift_count = cnt_q, d_out feeds acc's next-state mux.

## Test plan
- Reset: hold rst high for 2 cycles → cmd_ready = 1, res_valid = 0, busy = 0, res_data = 0x00.
- cmd_data 0x81, op ROL, count 1, reps 3 → res_valid after E3, res_data = 0x0C (passes: 0x03, 0x06, 0x0C).
- cmd_data 0x80, op ASR, count 3, reps 3 → res_data = 0xFF (passes: 0xF0, 0xFE, 0xFF).
- cmd_data 0x96, op LSR, count 2, reps 0 → res_valid in the cycle after E0, res_data = 0x96.
- Backpressure: reps 2, res_ready held low for 5 cycles in DONE →
  - res_valid and res_data stay stable, cmd_ready stays 0, and a concurrent cmd_valid is ignored;
  - raising res_ready → IDLE and cmd_ready = 1 in the next cycle.
- Reset mid-EXEC: cmd_data 0x01, op LSL, count 1, reps 10; pulse rst on the 2nd EXEC cycle →
  - IDLE on the next cycle, res_data = 0x00;
  - res_valid never asserted for that command.
